// File: rtl/interrupt_pkg.sv
// rtl/interrupt_pkg.sv - shared interrupt line widths and vector types
// Purpose: common sizing for interrupt_gateway and interrupt_controller.
// Ports: none (package).
package interrupt_pkg;

  localparam int INTERRUPT_LINES = 16;
  localparam int INTERRUPT_BITS  = $clog2(INTERRUPT_LINES);
  localparam int FILTER_BITS     = 4;

  typedef logic [INTERRUPT_LINES-1:0] irq_vec_t;
  typedef logic [FILTER_BITS-1:0]     filter_len_t;

endpackage

// File: rtl/irq_line_filter.sv
// rtl/irq_line_filter.sv - one interrupt line: synchronizer, polarity, stable-count filter
// Purpose: turns one raw asynchronous wire into a filtered, polarity-adjusted level.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   raw          raw asynchronous input
//   pol          current polarity bit (1 = active-low line)
//   pol_load     polarity bit is being flipped this cycle
//   filter_len   required stable cycles minus one
//   sync_out     synchronized, polarity-adjusted, unfiltered level
//   level_out    filtered level
module irq_line_filter
  import interrupt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   raw,
  input  logic                   pol,
  input  logic                   pol_load,
  input  logic [FILTER_BITS-1:0] filter_len,
  output logic                   sync_out,
  output logic                   level_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILTER_BITS-1:0] cnt_q;
  logic                   level_q;
  logic                   s;
  logic                   p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign p        = s ^ pol;
  assign sync_out = p;

  // pol_load only fires when the bit flips, so the new polarity is ~pol.
  // The >= compare keeps the counter from ever wrapping, and lets a
  // shortened filter_len release an in-flight count on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (pol_load) begin
      level_q <= s ^ ~pol;
      cnt_q   <= '0;
    end else if (p == level_q) begin
      cnt_q   <= '0;
    end else if (cnt_q >= filter_len) begin
      level_q <= p;
      cnt_q   <= '0;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign level_out = level_q;

endmodule

// File: rtl/interrupt_gateway.sv
// rtl/interrupt_gateway.sv - conditions raw device interrupts into clean levels
// Purpose: per-line synchronizer, software polarity inversion and glitch filter
//          feeding interrupt_controller.interrupt_id.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   irq_raw                         raw asynchronous device lines
//   polarity_we/wdata, polarity_val polarity register write / read
//   filter_we/wdata, filter_val     filter length register write / read
//   irq_sync                        synchronized, polarity-adjusted, unfiltered status
//   interrupt_id                    filtered levels to the controller
module interrupt_gateway
  import interrupt_pkg::*;
#(
  parameter int INTERRUPT_LINES = interrupt_pkg::INTERRUPT_LINES,
  parameter int SYNC_STAGES     = 2,
  parameter int FILTER_BITS     = interrupt_pkg::FILTER_BITS,
  parameter int FILTER_RESET    = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INTERRUPT_LINES-1:0] irq_raw,
  input  logic                       polarity_we,
  input  logic [INTERRUPT_LINES-1:0] polarity_wdata,
  output logic [INTERRUPT_LINES-1:0] polarity_val,
  input  logic                       filter_we,
  input  logic [FILTER_BITS-1:0]     filter_wdata,
  output logic [FILTER_BITS-1:0]     filter_val,
  output logic [INTERRUPT_LINES-1:0] irq_sync,
  output logic [INTERRUPT_LINES-1:0] interrupt_id
);

  logic [INTERRUPT_LINES-1:0] polarity_q;
  logic [FILTER_BITS-1:0]     filter_q;
  logic [INTERRUPT_LINES-1:0] pol_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      polarity_q <= '0;
      filter_q   <= FILTER_BITS'(FILTER_RESET);
    end else begin
      if (polarity_we) polarity_q <= polarity_wdata;
      if (filter_we)   filter_q   <= filter_wdata;
    end
  end

  // Only lines whose polarity bit actually changes get their output reloaded.
  assign pol_load     = {INTERRUPT_LINES{polarity_we}} & (polarity_wdata ^ polarity_q);
  assign polarity_val = polarity_q;
  assign filter_val   = filter_q;

  for (genvar i = 0; i < INTERRUPT_LINES; i++) begin : g_line
    irq_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_BITS (FILTER_BITS)
    ) u_line (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw        (irq_raw[i]),
      .pol        (polarity_q[i]),
      .pol_load   (pol_load[i]),
      .filter_len (filter_q),
      .sync_out   (irq_sync[i]),
      .level_out  (interrupt_id[i])
    );
  end

endmodule
